wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant, 1-cycle grant latency, requests mux to a shared slave.
// Grant holds for the whole cyc; other master waits. Optional ack timeout via `WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_wb_adr_i,
    input  logic [DATA_W-1:0] m0_wb_dat_i,
    input  logic              m0_wb_we_i,
    input  logic              m0_wb_stb_i,
    input  logic              m0_wb_cyc_i,
    input  logic [STRB_W-1:0] m0_wb_sel_i,
    output logic [DATA_W-1:0] m0_wb_dat_o,
    output logic              m0_wb_ack_o,
    output logic              m0_wb_err_o,
    input  logic [ADDR_W-1:0] m1_wb_adr_i,
    input  logic [DATA_W-1:0] m1_wb_dat_i,
    input  logic              m1_wb_we_i,
    input  logic              m1_wb_stb_i,
    input  logic              m1_wb_cyc_i,
    input  logic [STRB_W-1:0] m1_wb_sel_i,
    output logic [DATA_W-1:0] m1_wb_dat_o,
    output logic              m1_wb_ack_o,
    output logic              m1_wb_err_o,
    output logic [ADDR_W-1:0] s_wb_adr_o,
    output logic [DATA_W-1:0] s_wb_dat_o,
    output logic              s_wb_we_o,
    output logic              s_wb_stb_o,
    output logic              s_wb_cyc_o,
    output logic [STRB_W-1:0] s_wb_sel_o,
    input  logic [DATA_W-1:0] s_wb_dat_i,
    input  logic              s_wb_ack_i,
    output logic [1:0]        gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_last;
    logic [1:0] r_gnt;
    logic       w_req0;
    logic       w_req1;

    assign w_req0 = m0_wb_cyc_i & m0_wb_stb_i;
    assign w_req1 = m1_wb_cyc_i & m1_wb_stb_i;
    assign gnt_o  = r_gnt;

    // r_last=1 after reset so master 0 wins the first contended request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 && (!w_req1 || r_last)) begin
                        r_state <= GNT0;
                        r_last  <= 1'b0;
                        r_gnt   <= 2'b01;
                    end else if (w_req1) begin
                        r_state <= GNT1;
                        r_last  <= 1'b1;
                        r_gnt   <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!m0_wb_cyc_i) begin
                        r_state <= IDLE;
                        r_gnt   <= 2'b00;
                    end
                end
                GNT1: begin
                    if (!m1_wb_cyc_i) begin
                        r_state <= IDLE;
                        r_gnt   <= 2'b00;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        s_wb_adr_o  = '0;
        s_wb_dat_o  = '0;
        s_wb_we_o   = 1'b0;
        s_wb_stb_o  = 1'b0;
        s_wb_cyc_o  = 1'b0;
        s_wb_sel_o  = '0;
        m0_wb_ack_o = 1'b0;
        m1_wb_ack_o = 1'b0;
        case (r_state)
            GNT0: begin
                s_wb_adr_o  = m0_wb_adr_i;
                s_wb_dat_o  = m0_wb_dat_i;
                s_wb_we_o   = m0_wb_we_i;
                s_wb_stb_o  = m0_wb_stb_i;
                s_wb_cyc_o  = m0_wb_cyc_i;
                s_wb_sel_o  = m0_wb_sel_i;
                m0_wb_ack_o = s_wb_ack_i;
            end
            GNT1: begin
                s_wb_adr_o  = m1_wb_adr_i;
                s_wb_dat_o  = m1_wb_dat_i;
                s_wb_we_o   = m1_wb_we_i;
                s_wb_stb_o  = m1_wb_stb_i;
                s_wb_cyc_o  = m1_wb_cyc_i;
                s_wb_sel_o  = m1_wb_sel_i;
                m1_wb_ack_o = s_wb_ack_i;
            end
            default: ;
        endcase
    end

    assign m0_wb_dat_o = s_wb_dat_i;
    assign m1_wb_dat_o = s_wb_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_tmo_cnt;
    logic        w_wait;
    logic        w_tmo_hit;

    assign w_wait    = (r_state != IDLE) & s_wb_cyc_o & s_wb_stb_o & ~s_wb_ack_i;
    assign w_tmo_hit = w_wait & (r_tmo_cnt == TMO_LAST);

    // Counter holds the number of earlier unacked cycles; the error fires during the TIMEOUT-th one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= 16'd0;
        end else if ((r_state == IDLE) || !s_wb_cyc_o || s_wb_ack_i) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_wait) begin
            r_tmo_cnt <= w_tmo_hit ? 16'd0 : r_tmo_cnt + 16'd1;
        end
    end

    assign m0_wb_err_o = w_tmo_hit & (r_state == GNT0);
    assign m1_wb_err_o = w_tmo_hit & (r_state == GNT1);
`else
    assign m0_wb_err_o = 1'b0;
    assign m1_wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: grant latency, round-robin, hold, late ack, async reset, timeout.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] m0_adr, m1_adr, s_adr;
    logic [31:0] m0_dat, m1_dat, m0_rdat, m1_rdat, s_dat, s_rdat;
    logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic        s_we, s_stb, s_cyc, s_ack;
    logic [1:0]  gnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.ADDR_W(16), .DATA_W(32), .STRB_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_we_i(m0_we),
        .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc), .m0_wb_sel_i(m0_sel),
        .m0_wb_dat_o(m0_rdat), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
        .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_we_i(m1_we),
        .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc), .m1_wb_sel_i(m1_sel),
        .m1_wb_dat_o(m1_rdat), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
        .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat), .s_wb_we_o(s_we),
        .s_wb_stb_o(s_stb), .s_wb_cyc_o(s_cyc), .s_wb_sel_o(s_sel),
        .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack),
        .gnt_o(gnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        #3 reset = 1'b0;
        tick(); tick();
        #3 reset = 1'b1;
        tick();
    endtask

    initial begin
        reset  = 1'b0;
        m0_adr = '0; m0_dat = '0; m0_we = 0; m0_stb = 0; m0_cyc = 0; m0_sel = '0;
        m1_adr = '0; m1_dat = '0; m1_we = 0; m1_stb = 0; m1_cyc = 0; m1_sel = '0;
        s_rdat = '0; s_ack = 0;

        // Reset state
        tick(); settle();
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_cyc", 64'(s_cyc), 64'h0);
        s_ack = 1'b1; settle();
        chk("rst_ack0", 64'(m0_ack), 64'h0);
        chk("rst_err0", 64'(m0_err), 64'h0);
        s_ack = 1'b0;
        #3 reset = 1'b1;
        tick();

        // m0 single write
        m0_adr = 16'h0010; m0_dat = 32'hDEADBEEF; m0_sel = 4'hF;
        m0_we = 1; m0_stb = 1; m0_cyc = 1;
        settle();
        chk("wr_lat_gnt", 64'(gnt), 64'h0);
        chk("wr_lat_cyc", 64'(s_cyc), 64'h0);
        tick(); settle();
        chk("wr_gnt", 64'(gnt), 64'h1);
        chk("wr_adr", 64'(s_adr), 64'h0010);
        chk("wr_dat", 64'(s_dat), 64'hDEADBEEF);
        chk("wr_ctl", 64'({s_we, s_stb, s_cyc, s_sel}), 64'h7F);
        chk("wr_ack_early", 64'(m0_ack), 64'h0);
        tick();
        s_ack = 1; settle();
        chk("wr_ack0", 64'(m0_ack), 64'h1);
        chk("wr_ack1", 64'(m1_ack), 64'h0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0; settle();
        chk("wr_ack0_low", 64'(m0_ack), 64'h0);
        tick(); settle();
        chk("wr_idle", 64'(gnt), 64'h0);
        chk("wr_idle_adr", 64'(s_adr), 64'h0);

        // Round-robin from a fresh reset: m0, m1, m0
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick(); settle();
        chk("rr1_gnt", 64'(gnt), 64'h1);
        tick();
        m0_cyc = 0; m0_stb = 0;
        tick(); settle();
        chk("rr_handover_idle", 64'(gnt), 64'h0);
        tick(); settle();
        chk("rr2_gnt", 64'(gnt), 64'h2);
        m1_cyc = 0; m1_stb = 0;
        tick(); settle();
        chk("rr2_idle", 64'(gnt), 64'h0);
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick(); settle();
        chk("rr3_gnt", 64'(gnt), 64'h1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick(); settle();
        chk("rr3_idle", 64'(gnt), 64'h0);

        // m1 read keeps grant while m0 requests
        m1_adr = 16'h0004; m1_we = 0; m1_sel = 4'hF; m1_cyc = 1; m1_stb = 1;
        m0_adr = 16'h0020;
        tick(); settle();
        chk("rd_gnt", 64'(gnt), 64'h2);
        m0_cyc = 1; m0_stb = 1;
        tick(); settle();
        chk("rd_hold", 64'(gnt), 64'h2);
        chk("rd_adr", 64'(s_adr), 64'h0004);
        chk("rd_we", 64'(s_we), 64'h0);
        s_rdat = 32'h12345678; s_ack = 1; settle();
        chk("rd_ack1", 64'(m1_ack), 64'h1);
        chk("rd_ack0", 64'(m0_ack), 64'h0);
        chk("rd_dat1", 64'(m1_rdat), 64'h12345678);
        chk("rd_dat0_bcast", 64'(m0_rdat), 64'h12345678);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        tick(); settle();
        chk("rd_release_idle", 64'(gnt), 64'h0);
        tick(); settle();
        chk("rd_m0_gnt", 64'(gnt), 64'h1);
        chk("rd_m0_adr", 64'(s_adr), 64'h0020);

        // m0 drops cyc before ack; late ack goes nowhere
        m0_cyc = 0; m0_stb = 0;
        tick();
        s_ack = 1; settle();
        chk("late_gnt", 64'(gnt), 64'h0);
        chk("late_ack", 64'({m0_ack, m1_ack}), 64'h0);
        s_ack = 0;

        // Async reset in the middle of an m1 grant
        m1_cyc = 1; m1_stb = 1;
        tick(); settle();
        chk("ar_pre_gnt", 64'(gnt), 64'h2);
        m0_cyc = 1; m0_stb = 1; s_ack = 1;
        #2 reset = 0;
        #1;
        chk("ar_gnt", 64'(gnt), 64'h0);
        chk("ar_cyc", 64'(s_cyc), 64'h0);
        chk("ar_ack1", 64'(m1_ack), 64'h0);
        tick(); settle();
        chk("ar_hold", 64'({gnt, s_stb}), 64'h0);
        s_ack = 0;
        #3 reset = 1;
        tick(); settle();
        chk("ar_m0_wins", 64'(gnt), 64'h1);
        m1_cyc = 0; m1_stb = 0;

        // Slave never acks: error pulse on every 8th waiting cycle when enabled
        for (int k = 1; k <= 24; k++) begin
            if (k > 1) begin
                tick(); settle();
            end
`ifdef WB_ARB_TIMEOUT_EN
            chk($sformatf("tmo_err0_c%0d", k), 64'(m0_err), 64'((k % 8) == 0));
`else
            chk($sformatf("tmo_err0_c%0d", k), 64'(m0_err), 64'h0);
`endif
            chk($sformatf("tmo_err1_c%0d", k), 64'(m1_err), 64'h0);
        end
        chk("tmo_keep_gnt", 64'(gnt), 64'h1);
        m0_cyc = 0; m0_stb = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
